ultrasonic_scheduler: RTL and testbench

Sequences the robot's three ultrasonic rangers round-robin (left=0, centre=1, right=2) so only one sensor pings at a time, avoiding acoustic crosstalk. For each sensor it generates the trigger pulse, times the echo with a timeout, and compares the echo width against a distance threshold. Produces the 3-bit obstacle vector consumed by the drive-direction logic and the LEDs, plus a per-measurement result strobe.

---
 rtl/ultrasonic_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_scheduler.sv
// ---------------------------------------------------------------------------
// ultrasonic_scheduler
//
// Round-robin sequencer for the robot's three ultrasonic rangers
// (0 = left, 1 = centre, 2 = right). Only one sensor is pinged at a time so
// the sensors do not hear each other's bursts. For the selected sensor the
// block drives the trigger pulse, times the returning echo (with a timeout
// both for the rise and for the echo width), and flags an obstacle when the
// echo is shorter than the distance threshold.
//
// Build option:
//   US_FILTER_EN - when defined, an obstacle bit only changes after two
//                  consecutive measurements of that sensor agree. When not
//                  defined, each obstacle bit follows the latest result.
// ---------------------------------------------------------------------------
module ultrasonic_scheduler #(
   parameter int TRIG_CYCLES    = 500,
   parameter int TIMEOUT_CYCLES = 1900000,
   parameter int GAP_CYCLES     = 3000000,
   parameter int THRESH_CYCLES  = 58000,
   parameter int CNT_W          = 24
) (
   input  logic             fpgaclk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       echo,
   output logic [2:0]       trigger,
   output logic [2:0]       obstacle,
   output logic             dist_valid,
   output logic [1:0]       dist_id,
   output logic [CNT_W-1:0] dist_cycles,
   output logic             timeout
);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      DONE,
      GAP
   } state_t;

   // Counter compare points, pre-sized to the counter width.
   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_FULL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] THRESH       = CNT_W'(THRESH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   state_t           state;
   logic [1:0]       idx;
   logic [CNT_W-1:0] cnt;

   logic [2:0]       echo_meta;
   logic [2:0]       echo_sync;
   logic             echo_sel;

   logic             fin;
   logic [CNT_W-1:0] fin_width;
   logic             fin_timeout;
   logic             fin_raw;
   logic [1:0]       next_idx;

`ifdef US_FILTER_EN
   logic [2:0]       pending;
`endif

   // Two-flop synchronizer on every echo line; the sensors run off their own
   // timing so the raw inputs are fully asynchronous to fpgaclk.
   always_ff @(posedge fpgaclk or negedge rst) begin
      if (!rst) begin
         echo_meta <= 3'b000;
         echo_sync <= 3'b000;
      end else begin
         echo_meta <= echo;
         echo_sync <= echo_meta;
      end
   end

   // Only the sensor currently being served is ever looked at.
   assign echo_sel = echo_sync[idx];

   assign next_idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;

   // Decide whether this cycle ends the measurement, and with what result.
   // In WAIT_RISE the counter holds the cycles already waited; in MEASURE it
   // holds the echo-high cycles already seen, so the current high cycle is
   // the (cnt+1)-th one.
   always_comb begin
      fin         = 1'b0;
      fin_width   = cnt;
      fin_timeout = 1'b0;
      case (state)
         WAIT_RISE: begin
            if (!echo_sel && (cnt == TIMEOUT_LAST)) begin
               fin         = 1'b1;
               fin_width   = '0;
               fin_timeout = 1'b1;
            end
         end
         MEASURE: begin
            if (!echo_sel) begin
               fin         = 1'b1;
               fin_width   = cnt;
               fin_timeout = 1'b0;
            end else if (cnt == TIMEOUT_LAST) begin
               fin         = 1'b1;
               fin_width   = TIMEOUT_FULL;
               fin_timeout = 1'b1;
            end
         end
         default: begin
            fin         = 1'b0;
            fin_width   = cnt;
            fin_timeout = 1'b0;
         end
      endcase
      fin_raw = !fin_timeout && (fin_width < THRESH);
   end

   // Main sequencer: trigger, wait for the echo, time it, report, then rest.
   // Dropping en aborts whatever is in flight and parks in IDLE without
   // moving to the next sensor, so a re-enable retries the same one.
   always_ff @(posedge fpgaclk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         idx         <= 2'd0;
         cnt         <= '0;
         trigger     <= 3'b000;
         obstacle    <= 3'b000;
         dist_valid  <= 1'b0;
         dist_id     <= 2'd0;
         dist_cycles <= '0;
         timeout     <= 1'b0;
`ifdef US_FILTER_EN
         pending     <= 3'b000;
`endif
      end else begin
         dist_valid <= 1'b0;
         if (!en) begin
            state   <= IDLE;
            cnt     <= '0;
            trigger <= 3'b000;
         end else begin
            case (state)
               IDLE: begin
                  state   <= TRIG;
                  cnt     <= '0;
                  trigger <= 3'b001 << idx;
               end
               TRIG: begin
                  if (cnt == TRIG_LAST) begin
                     state   <= WAIT_RISE;
                     cnt     <= '0;
                     trigger <= 3'b000;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               WAIT_RISE, MEASURE: begin
                  if ((state == WAIT_RISE) && echo_sel) begin
                     // An echo that is already high here (stale) counts as
                     // the rise; this first high cycle is part of the width.
                     state <= MEASURE;
                     cnt   <= CNT_ONE;
                  end else if (fin) begin
                     state       <= DONE;
                     cnt         <= '0;
                     dist_valid  <= 1'b1;
                     dist_id     <= idx;
                     dist_cycles <= fin_width;
                     timeout     <= fin_timeout;
`ifdef US_FILTER_EN
                     if (pending[idx] == fin_raw) begin
                        obstacle[idx] <= fin_raw;
                     end
                     pending[idx] <= fin_raw;
`else
                     obstacle[idx] <= fin_raw;
`endif
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               DONE: begin
                  state <= GAP;
                  cnt   <= '0;
               end
               GAP: begin
                  // en is known to be high here (low is handled above), so
                  // the end of the dead time always launches the next ping.
                  if (cnt == GAP_LAST) begin
                     idx     <= next_idx;
                     cnt     <= '0;
                     state   <= TRIG;
                     trigger <= 3'b001 << next_idx;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  state   <= IDLE;
                  cnt     <= '0;
                  trigger <= 3'b000;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ultrasonic_scheduler
//
// Self-checking bench for ultrasonic_scheduler with small parameters
// (TRIG=4, TIMEOUT=100, GAP=10, THRESH=50). A measurement-level model keeps
// the expected sensor order, result fields and obstacle vector; a per-cycle
// monitor compares the DUT against it. Honours US_FILTER_EN when defined.
// ---------------------------------------------------------------------------
module tb_ultrasonic_scheduler;

   localparam int TRIG = 4;
   localparam int TMO  = 100;
   localparam int GAP  = 10;
   localparam int THR  = 50;
   localparam int CW   = 24;

   logic          fpgaclk = 1'b0;
   logic          rst     = 1'b0;
   logic          en      = 1'b0;
   logic [2:0]    echo    = 3'b000;
   logic [2:0]    trigger;
   logic [2:0]    obstacle;
   logic          dist_valid;
   logic [1:0]    dist_id;
   logic [CW-1:0] dist_cycles;
   logic          timeout;

   int         checks = 0;
   int         failures = 0;

   int         expIdx = 0;
   bit         expectStrobe = 1'b0;
   bit         monitorOn = 1'b0;
   int         expId = 0;
   int         expCycles = 0;
   bit         expTo = 1'b0;
   int         heldId = 0;
   int         heldCycles = 0;
   bit         heldTo = 1'b0;
   logic [2:0] obsModel = 3'b000;
   logic [2:0] pendModel = 3'b000;

   ultrasonic_scheduler #(
      .TRIG_CYCLES   (TRIG),
      .TIMEOUT_CYCLES(TMO),
      .GAP_CYCLES    (GAP),
      .THRESH_CYCLES (THR),
      .CNT_W         (CW)
   ) dut (
      .fpgaclk    (fpgaclk),
      .rst        (rst),
      .en         (en),
      .echo       (echo),
      .trigger    (trigger),
      .obstacle   (obstacle),
      .dist_valid (dist_valid),
      .dist_id    (dist_id),
      .dist_cycles(dist_cycles),
      .timeout    (timeout)
   );

   // 100 MHz-style free-running clock.
   always #5 fpgaclk = ~fpgaclk;

   function automatic logic [2:0] oneHot(input int i);
      return 3'b001 << i;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint required);
      checks++;
      if (actual != required) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
      end
   endtask

   // Fold a finished measurement into the model: result fields are held and
   // the obstacle bit follows the distance rule (optionally debounced).
   task automatic commitResult();
      bit raw;
      raw        = !expTo && (expCycles < THR);
      heldId     = expId;
      heldCycles = expCycles;
      heldTo     = expTo;
`ifdef US_FILTER_EN
      if (raw == pendModel[expId]) obsModel[expId] = raw;
      pendModel[expId] = raw;
`else
      obsModel[expId] = raw;
`endif
   endtask

   // Per-cycle monitor: never two triggers at once, strobes only when a
   // measurement is due, and every reported field matches the model.
   initial begin
      forever begin
         @(negedge fpgaclk);
         if (monitorOn && rst) begin
            checkOutput("trigger_onehot", ($countones(trigger) <= 1), 1);
            if (dist_valid) begin
               checkOutput("strobe_expected", expectStrobe, 1);
               if (expectStrobe) begin
                  commitResult();
                  expectStrobe = 1'b0;
               end
            end
            checkOutput("dist_id", dist_id, heldId);
            checkOutput("dist_cycles", dist_cycles, heldCycles);
            checkOutput("timeout", timeout, heldTo);
            checkOutput("obstacle", obstacle, obsModel);
         end
      end
   end

   // One full measurement on the expected sensor.
   // kind 0: echo high for w cycles, kind 1: no echo, kind 2: echo stuck high.
   task automatic applyStimulus(input int kind, input int w, input bit noise);
      int         n;
      int         hi;
      int         t;
      int         d;
      int         lat;
      bit         seen;
      logic [2:0] want;
      want = oneHot(expIdx);
      if (kind == 2) echo[expIdx] = 1'b1;
      n = 0;
      while (trigger == 3'b000 && n < 300) begin
         @(negedge fpgaclk);
         n++;
      end
      checkOutput("trigger_select", trigger, want);
      if (trigger != want) begin
         echo = 3'b000;
         return;
      end
      expId = expIdx;
      if (kind == 1) begin
         expCycles = 0;
         expTo     = 1'b1;
      end else if (kind == 2 || w >= TMO) begin
         expCycles = TMO;
         expTo     = 1'b1;
      end else begin
         expCycles = w;
         expTo     = 1'b0;
      end
      expectStrobe = 1'b1;
      hi = 0;
      while (trigger != 3'b000 && hi < 50) begin
         @(negedge fpgaclk);
         hi++;
      end
      checkOutput("trigger_width", hi, TRIG);
      d    = noise ? int'($urandom_range(0, 5)) : 2;
      t    = 0;
      seen = 1'b0;
      lat  = 0;
      while (t < TMO + 60 && !(seen && (kind != 0 || t >= d + w))) begin
         for (int k = 0; k < 3; k++) begin
            if (k != expIdx) echo[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         if (kind == 0) echo[expIdx] = (t >= d) && (t < d + w);
         @(negedge fpgaclk);
         t++;
         if (dist_valid && !seen) begin
            seen = 1'b1;
            lat  = t;
         end
      end
      echo = 3'b000;
      checkOutput("strobe_seen", seen, 1);
      if (!seen) expectStrobe = 1'b0;
      if (kind == 1) checkOutput("rise_timeout_latency", lat, TMO);
      expIdx = (expIdx + 1) % 3;
   endtask

   // Drop en while the echo is being timed; nothing may be reported.
   task automatic abortInMeasure();
      int n;
      n = 0;
      while (trigger == 3'b000 && n < 300) begin
         @(negedge fpgaclk);
         n++;
      end
      checkOutput("abort_m_select", trigger, oneHot(expIdx));
      n = 0;
      while (trigger != 3'b000 && n < 50) begin
         @(negedge fpgaclk);
         n++;
      end
      repeat (2) @(negedge fpgaclk);
      echo[expIdx] = 1'b1;
      repeat (12) @(negedge fpgaclk);
      en = 1'b0;
      @(negedge fpgaclk);
      for (int i = 0; i < 20; i++) begin
         checkOutput("abort_m_trigger_low", trigger, 0);
         if (i == 5) echo = 3'b000;
         @(negedge fpgaclk);
      end
      en = 1'b1;
   endtask

   // Drop en in the middle of a trigger pulse; the pulse must end at once.
   task automatic abortInTrig();
      int n;
      n = 0;
      while (trigger == 3'b000 && n < 300) begin
         @(negedge fpgaclk);
         n++;
      end
      checkOutput("abort_t_select", trigger, oneHot(expIdx));
      en = 1'b0;
      @(negedge fpgaclk);
      checkOutput("abort_t_trigger_clear", trigger, 0);
      repeat (3) @(negedge fpgaclk);
      en = 1'b1;
   endtask

   // Safety net so the run always ends.
   initial begin
      #2000000;
      failures++;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized measurements.
   initial begin
      int seqW[5];
      int seqObs[5];
      int kind;
      seqW = '{30, 80, 80, 30, 30};
`ifdef US_FILTER_EN
      seqObs = '{0, 0, 0, 0, 1};
`else
      seqObs = '{1, 0, 0, 1, 1};
`endif

      rst = 1'b0;
      en  = 1'b0;
      repeat (3) @(negedge fpgaclk);
      checkOutput("reset_trigger", trigger, 0);
      checkOutput("reset_obstacle", obstacle, 0);
      checkOutput("reset_dist_valid", dist_valid, 0);
      checkOutput("reset_dist_id", dist_id, 0);
      checkOutput("reset_dist_cycles", dist_cycles, 0);
      checkOutput("reset_timeout", timeout, 0);
      rst = 1'b1;
      repeat (3) @(negedge fpgaclk);
      checkOutput("idle_trigger", trigger, 0);
      monitorOn = 1'b1;
      en = 1'b1;

      applyStimulus(0, 30, 1'b0);
      checkOutput("s0_dist_id", dist_id, 0);
      checkOutput("s0_dist_cycles", dist_cycles, 30);
      checkOutput("s0_timeout", timeout, 0);
`ifdef US_FILTER_EN
      checkOutput("s0_obstacle", obstacle, 3'b000);
`else
      checkOutput("s0_obstacle", obstacle, 3'b001);
`endif

      applyStimulus(0, 60, 1'b0);
      checkOutput("s1_dist_id", dist_id, 1);
      checkOutput("s1_dist_cycles", dist_cycles, 60);
      checkOutput("s1_obstacle1", obstacle[1], 0);

      applyStimulus(1, 0, 1'b0);
      checkOutput("s2_dist_id", dist_id, 2);
      checkOutput("s2_timeout", timeout, 1);
      checkOutput("s2_dist_cycles", dist_cycles, 0);
      checkOutput("s2_obstacle2", obstacle[2], 0);

      applyStimulus(2, 0, 1'b0);
      checkOutput("stuck_dist_id", dist_id, 0);
      checkOutput("stuck_dist_cycles", dist_cycles, TMO);
      checkOutput("stuck_timeout", timeout, 1);
      checkOutput("stuck_obstacle0", obstacle[0], 0);

      applyStimulus(0, THR, 1'b0);
      checkOutput("thresh_equal_obstacle1", obstacle[1], 0);
      applyStimulus(0, THR - 1, 1'b0);
`ifdef US_FILTER_EN
      checkOutput("thresh_below_obstacle2", obstacle[2], 0);
`else
      checkOutput("thresh_below_obstacle2", obstacle[2], 1);
`endif

      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, seqW[i], 1'b0);
         checkOutput("seq_obstacle0", obstacle[0], seqObs[i]);
         if (i < 4) begin
            applyStimulus(0, 70, 1'b1);
            applyStimulus(0, 70, 1'b1);
         end
      end

      abortInMeasure();
      applyStimulus(0, 20, 1'b1);
      abortInTrig();
      applyStimulus(0, 55, 1'b1);

      // Asynchronous reset in the middle of a trigger pulse.
      begin
         int n;
         n = 0;
         while (trigger == 3'b000 && n < 300) begin
            @(negedge fpgaclk);
            n++;
         end
         checkOutput("pre_reset_trigger", trigger, oneHot(expIdx));
         @(posedge fpgaclk);
         #2;
         rst          = 1'b0;
         obsModel     = 3'b000;
         pendModel    = 3'b000;
         heldId       = 0;
         heldCycles   = 0;
         heldTo       = 1'b0;
         expIdx       = 0;
         expectStrobe = 1'b0;
         #1;
         checkOutput("async_trigger", trigger, 0);
         checkOutput("async_obstacle", obstacle, 0);
         checkOutput("async_dist_valid", dist_valid, 0);
         checkOutput("async_dist_id", dist_id, 0);
         checkOutput("async_dist_cycles", dist_cycles, 0);
         checkOutput("async_timeout", timeout, 0);
         repeat (3) @(negedge fpgaclk);
         rst = 1'b1;
      end

      for (int i = 0; i < 24; i++) begin
         kind = ($urandom_range(0, 9) < 2) ? 1 : 0;
         applyStimulus(kind, int'($urandom_range(1, 105)), 1'b1);
      end

      repeat (5) @(negedge fpgaclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
